// File: rtl/kairo_mem_pkg.sv
// kairo_mem_pkg: shared types and constants for the unified
// I/D memory arbiter and the shared-resource helpers around it.
package kairo_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_e;

  localparam int RD_LAT_MAX = 3;

  // Address-window select field.
  localparam int WIN_HI = 31;
  localparam int WIN_LO = 28;

endpackage

// File: rtl/kairo_rr_arb2.sv
// kairo_rr_arb2: combinational 2-way round-robin arbiter.
// Ports: i_req[1:0] requests, i_last_grant (1 = req[1] last),
// o_gnt[1:0] one-hot grant.
module kairo_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    unique case (1'b1)
      (&i_req):           o_gnt = i_last_grant ? 2'b01 : 2'b10;
      (i_req == 2'b01):   o_gnt = 2'b01;
      (i_req == 2'b10):   o_gnt = 2'b10;
      default:            o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/kairo_mem_arb.sv
// kairo_mem_arb: shares one single-port SRAM between the core's
// instruction and data ports with round-robin arbitration.
// Ports: CLK, RST_N; I_MEM_* / D_MEM_* requester buses
// (VALID/ADDR/WDATA/WSTB in, READY/RDATA/EXCPT out);
// MEM_EN/MEM_ADR/MEM_WEB/MEM_WDIN to the SRAM, MEM_RDOUT back.
module kairo_mem_arb
  import kairo_mem_pkg::*;
#(
  parameter int         RD_LAT   = 1,
  parameter logic [3:0] MEM_BASE = 4'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        I_MEM_VALID,
  input  logic [31:0] I_MEM_ADDR,
  input  logic [31:0] I_MEM_WDATA,
  input  logic [3:0]  I_MEM_WSTB,
  output logic        I_MEM_READY,
  output logic [31:0] I_MEM_RDATA,
  output logic        I_MEM_EXCPT,
  input  logic        D_MEM_VALID,
  input  logic [31:0] D_MEM_ADDR,
  input  logic [31:0] D_MEM_WDATA,
  input  logic [3:0]  D_MEM_WSTB,
  output logic        D_MEM_READY,
  output logic [31:0] D_MEM_RDATA,
  output logic        D_MEM_EXCPT,
  output logic        MEM_EN,
  output logic [31:0] MEM_ADR,
  output logic [3:0]  MEM_WEB,
  output logic [31:0] MEM_WDIN,
  input  logic [31:0] MEM_RDOUT
);

  localparam int LW = $clog2(RD_LAT_MAX);

  state_e        r_state, w_state_nxt;
  grant_e        r_grant, w_grant_nxt;
  grant_e        r_last, w_last_nxt;
  logic [LW-1:0] r_lat_cnt, w_lat_cnt_nxt;
  logic          r_excpt, w_excpt_nxt;
  logic          r_wr, w_wr_nxt;

  logic [1:0]    w_gnt;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstb;
  logic          w_in_win;
  logic          w_other_v;
  logic [31:0]   w_rdata;

  kairo_rr_arb2 u_rr (
    .i_req        ({D_MEM_VALID, I_MEM_VALID}),
    .i_last_grant (r_last == GNT_D),
    .o_gnt        (w_gnt)
  );

  assign w_addr    = (r_grant == GNT_D) ? D_MEM_ADDR  : I_MEM_ADDR;
  assign w_wdata   = (r_grant == GNT_D) ? D_MEM_WDATA : I_MEM_WDATA;
  assign w_wstb    = (r_grant == GNT_D) ? D_MEM_WSTB  : I_MEM_WSTB;
  assign w_other_v = (r_grant == GNT_D) ? I_MEM_VALID : D_MEM_VALID;
  assign w_in_win  = (w_addr[WIN_HI:WIN_LO] == MEM_BASE);

  // Writes and out-of-window accesses return zero data.
  assign w_rdata = (r_excpt || r_wr) ? 32'h0 : MEM_RDOUT;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_grant   <= GNT_I;
      r_last    <= GNT_D;
      r_lat_cnt <= '0;
      r_excpt   <= 1'b0;
      r_wr      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_excpt   <= w_excpt_nxt;
      r_wr      <= w_wr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_lat_cnt_nxt = r_lat_cnt;
    w_excpt_nxt   = r_excpt;
    w_wr_nxt      = r_wr;
    I_MEM_READY   = 1'b0;
    I_MEM_RDATA   = 32'h0;
    I_MEM_EXCPT   = 1'b0;
    D_MEM_READY   = 1'b0;
    D_MEM_RDATA   = 32'h0;
    D_MEM_EXCPT   = 1'b0;
    MEM_EN        = 1'b0;
    MEM_ADR       = 32'h0;
    MEM_WEB       = 4'h0;
    MEM_WDIN      = 32'h0;
    unique case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_grant_nxt = w_gnt[1] ? GNT_D : GNT_I;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_excpt_nxt   = !w_in_win;
        w_wr_nxt      = |w_wstb;
        w_lat_cnt_nxt = LW'(RD_LAT - 1);
        w_state_nxt   = (RD_LAT == 1) ? RESP : WAIT;
        if (w_in_win) begin
          MEM_EN   = 1'b1;
          MEM_ADR  = w_addr >> 2;
          MEM_WEB  = w_wstb;
          MEM_WDIN = w_wdata;
        end
      end
      WAIT: begin
        w_lat_cnt_nxt = r_lat_cnt - LW'(1);
        if (r_lat_cnt == LW'(1)) w_state_nxt = RESP;
      end
      RESP: begin
        if (r_grant == GNT_I) begin
          I_MEM_READY = 1'b1;
          I_MEM_RDATA = w_rdata;
          I_MEM_EXCPT = r_excpt;
        end else begin
          D_MEM_READY = 1'b1;
          D_MEM_RDATA = w_rdata;
          D_MEM_EXCPT = r_excpt;
        end
        w_last_nxt = r_grant;
        // Hand over directly to a waiting opposite port.
        if (w_other_v) begin
          w_grant_nxt = (r_grant == GNT_I) ? GNT_D : GNT_I;
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_kairo_mem_arb.sv
// tb_kairo_mem_arb: directed and random checks of kairo_mem_arb
// at read latency 1 and 3 against a transaction-level model.
module tb_kairo_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int act = 0;

  logic [1:0]        iv, dv, ir, dr, ie, de, men;
  logic [1:0][31:0]  ia, iw, da, dw, ird, drd;
  logic [1:0][31:0]  madr, mwd, mrd;
  logic [1:0][3:0]   is, ds, mweb;

  // Requester state, index 0 = I port, 1 = D port.
  logic [1:0]        rv = 2'b00;
  logic [1:0][31:0]  raddr = '0, rwd = '0;
  logic [1:0][3:0]   rstb = '0;
  logic [1:0]        keep = 2'b00;
  logic              auto_on = 1'b0;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'(32'h0101_0101 * i) ^ 32'h5A00_0000;
  endfunction

  function automatic int lat(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [256];
    logic [31:0] p0, p1, p2;

    assign iv[g] = (act == g) && rv[0];
    assign dv[g] = (act == g) && rv[1];
    assign ia[g] = raddr[0];
    assign iw[g] = rwd[0];
    assign is[g] = rstb[0];
    assign da[g] = raddr[1];
    assign dw[g] = rwd[1];
    assign ds[g] = rstb[1];

    kairo_mem_arb #(
      .RD_LAT   ((g == 0) ? 1 : 3),
      .MEM_BASE (4'h0)
    ) u_dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .I_MEM_VALID (iv[g]),
      .I_MEM_ADDR  (ia[g]),
      .I_MEM_WDATA (iw[g]),
      .I_MEM_WSTB  (is[g]),
      .I_MEM_READY (ir[g]),
      .I_MEM_RDATA (ird[g]),
      .I_MEM_EXCPT (ie[g]),
      .D_MEM_VALID (dv[g]),
      .D_MEM_ADDR  (da[g]),
      .D_MEM_WDATA (dw[g]),
      .D_MEM_WSTB  (ds[g]),
      .D_MEM_READY (dr[g]),
      .D_MEM_RDATA (drd[g]),
      .D_MEM_EXCPT (de[g]),
      .MEM_EN      (men[g]),
      .MEM_ADR     (madr[g]),
      .MEM_WEB     (mweb[g]),
      .MEM_WDIN    (mwd[g]),
      .MEM_RDOUT   (mrd[g])
    );

    initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);

    // SRAM model: byte writes, read data after g-dependent latency.
    always @(posedge clk) begin
      if (men[g] && mweb[g] != 4'h0)
        for (int b = 0; b < 4; b++)
          if (mweb[g][b]) mem[madr[g][7:0]][8*b +: 8] = mwd[g][8*b +: 8];
      p0 <= (men[g] && mweb[g] == 4'h0) ? mem[madr[g][7:0]] : 32'hA5A5_A5A5;
      p1 <= p0;
      p2 <= p1;
    end
    assign mrd[g] = (g == 0) ? p0 : p2;
  end

  // Transaction-level reference: a grant decided in cycle c
  // completes in cycle c+1+L; issue happens in cycle c+1.
  logic [31:0] ref_mem [2][256];
  logic        busy = 1'b0;
  int          ep = 0;
  int          ecyc = 0;
  int          lastp = 1;
  logic [31:0] sa, swd;
  logic [3:0]  sst;
  logic        sin;

  int          done [2];
  int          rdy_cyc [2];
  logic [31:0] rd_cap [2];
  logic        ex_cap [2];
  int          obs_q [$];
  int          en_cnt = 0;
  logic [31:0] cap_adr, cap_wd;
  logic [3:0]  cap_web;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic snap(int p);
    sa  = raddr[p];
    swd = rwd[p];
    sst = rstb[p];
    sin = (raddr[p][31:28] == 4'h0);
  endtask

  task automatic model_update();
    int L;
    L = lat(act);
    if (!rst_n) begin
      busy  = 1'b0;
      lastp = 1;
      return;
    end
    if (busy && cyc == ecyc) begin
      if (sin && sst != 4'h0)
        for (int b = 0; b < 4; b++)
          if (sst[b]) ref_mem[act][sa[9:2]][8*b +: 8] = swd[8*b +: 8];
      lastp = ep;
      if (rv[1-ep]) begin
        ep   = 1 - ep;
        snap(ep);
        ecyc = cyc + 1 + L;
      end else begin
        busy = 1'b0;
      end
    end else if (!busy && rv != 2'b00) begin
      if (rv == 2'b11) ep = 1 - lastp;
      else             ep = rv[1] ? 1 : 0;
      snap(ep);
      busy = 1'b1;
      ecyc = cyc + 1 + L;
    end
  endtask

  task automatic check_cycle();
    int          L;
    logic [1:0]  er;
    logic [31:0] erd;
    logic        iss;
    L   = lat(act);
    er  = 2'b00;
    if (busy && cyc == ecyc) er[ep] = 1'b1;
    erd = (sin && sst == 4'h0) ? ref_mem[act][sa[9:2]] : 32'h0;
    chk("i_ready", 32'(ir[act]), 32'(er[0]));
    chk("d_ready", 32'(dr[act]), 32'(er[1]));
    chk("i_rdata", ird[act], er[0] ? erd : 32'h0);
    chk("d_rdata", drd[act], er[1] ? erd : 32'h0);
    chk("i_excpt", 32'(ie[act]), 32'(er[0] && !sin));
    chk("d_excpt", 32'(de[act]), 32'(er[1] && !sin));
    iss = busy && (cyc == ecyc - L);
    chk("mem_en", 32'(men[act]), 32'(iss && sin));
    chk("mem_web", 32'(mweb[act]), (iss && sin) ? 32'(sst) : 32'h0);
    if (iss && sin) begin
      chk("mem_adr", madr[act], sa >> 2);
      chk("mem_wdin", mwd[act], swd);
    end else if (!iss) begin
      chk("mem_adr_idle", madr[act], 32'h0);
      chk("mem_wdin_idle", mwd[act], 32'h0);
    end
  endtask

  task automatic new_req(int p);
    int r;
    r = int'($urandom_range(7));
    rv[p] = 1'b1;
    if (r == 0)
      raddr[p] = {4'($urandom_range(15, 1)), 28'($urandom)};
    else
      raddr[p] = {4'h0, 18'($urandom), 4'h0,
                  4'($urandom_range(15)), 2'($urandom)};
    rwd[p]  = $urandom;
    rstb[p] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
  endtask

  task automatic react();
    logic got;
    if (men[act]) begin
      en_cnt++;
      cap_adr = madr[act];
      cap_wd  = mwd[act];
      cap_web = mweb[act];
    end
    for (int p = 0; p < 2; p++) begin
      got = (p == 0) ? ir[act] : dr[act];
      if (got) begin
        done[p]++;
        rdy_cyc[p] = cyc;
        rd_cap[p]  = (p == 0) ? ird[act] : drd[act];
        ex_cap[p]  = (p == 0) ? ie[act] : de[act];
        obs_q.push_back(p);
        if (auto_on && $urandom_range(1) == 1) new_req(p);
        else if (!keep[p]) rv[p] = 1'b0;
      end else if (auto_on && !rv[p] && $urandom_range(2) == 0) begin
        new_req(p);
      end
    end
  endtask

  task automatic step();
    model_update();
    @(negedge clk);
    check_cycle();
    react();
  endtask

  task automatic run_until(int p, int n, int maxc, string tag);
    int k;
    k = 0;
    while (done[p] < n && k < maxc) begin
      step();
      k++;
    end
    chk(tag, 32'(done[p] >= n), 32'h1);
  endtask

  task automatic drain();
    int k;
    auto_on = 1'b0;
    keep    = 2'b00;
    k = 0;
    while ((rv != 2'b00 || busy) && k < 80) begin
      step();
      k++;
    end
    chk("drain", 32'(rv == 2'b00 && !busy), 32'h1);
  endtask

  task automatic reset_dut();
    rv    = 2'b00;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    done[0] = 0;
    done[1] = 0;
    en_cnt  = 0;
    obs_q.delete();
  endtask

  task automatic set_req(int p, logic [31:0] a, logic [31:0] w,
                         logic [3:0] s);
    raddr[p] = a;
    rwd[p]   = w;
    rstb[p]  = s;
    rv[p]    = 1'b1;
  endtask

  int          c0;
  logic [31:0] w2;

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(i);
    done[0] = 0;
    done[1] = 0;

    // Latency 1 instance.
    act = 0;
    reset_dut();

    // Single I read of the preloaded word.
    c0 = cyc;
    set_req(0, 32'h0000_0010, 32'h0, 4'h0);
    run_until(0, 1, 20, "t1_timeout");
    chk("t1_ready_cyc", 32'(rdy_cyc[0]), 32'(c0 + 2));
    chk("t1_rdata", rd_cap[0], 32'hDEAD_BEEF);
    chk("t1_adr", cap_adr, 32'h4);
    chk("t1_d_idle", 32'(done[1]), 32'h0);
    step();

    // Contention straight out of reset, held for four beats.
    reset_dut();
    c0   = cyc;
    keep = 2'b11;
    set_req(0, 32'h0000_0020, 32'h0, 4'h0);
    set_req(1, 32'h0000_0024, 32'h0, 4'h0);
    run_until(0, 1, 20, "t2_i_timeout");
    chk("t2_i_cyc", 32'(rdy_cyc[0]), 32'(c0 + 2));
    run_until(1, 2, 30, "t2_d_timeout");
    chk("t2_len", 32'(obs_q.size()), 32'h4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      chk("t2_order", 32'(obs_q[i]), 32'(i % 2));
    drain();

    // D write with a partial strobe.
    reset_dut();
    c0 = cyc;
    set_req(1, 32'h0000_0008, 32'h1234_5678, 4'b0011);
    run_until(1, 1, 20, "t3_timeout");
    chk("t3_ready_cyc", 32'(rdy_cyc[1]), 32'(c0 + 2));
    chk("t3_en_cnt", 32'(en_cnt), 32'h1);
    chk("t3_web", 32'(cap_web), 32'h3);
    chk("t3_adr", cap_adr, 32'h2);
    chk("t3_wdin", cap_wd, 32'h1234_5678);
    chk("t3_rdata", rd_cap[1], 32'h0);
    step();

    // Read back the merged word.
    w2 = init_word(2);
    set_req(0, 32'h0000_0008, 32'h0, 4'h0);
    run_until(0, 1, 20, "t3_rb_timeout");
    chk("t3_rb", rd_cap[0], {w2[31:16], 16'h5678});
    step();

    // Out-of-window D read.
    reset_dut();
    c0 = cyc;
    set_req(1, 32'h1000_0000, 32'h0, 4'h0);
    run_until(1, 1, 20, "t4_timeout");
    chk("t4_ready_cyc", 32'(rdy_cyc[1]), 32'(c0 + 2));
    chk("t4_excpt", 32'(ex_cap[1]), 32'h1);
    chk("t4_rdata", rd_cap[1], 32'h0);
    chk("t4_en_cnt", 32'(en_cnt), 32'h0);
    step();

    auto_on = 1'b1;
    repeat (400) step();
    drain();

    // Latency 3 instance.
    act = 1;
    reset_dut();
    c0 = cyc;
    set_req(0, 32'h0000_0010, 32'h0, 4'h0);
    run_until(0, 1, 20, "t5_timeout");
    chk("t5_ready_cyc", 32'(rdy_cyc[0]), 32'(c0 + 4));
    chk("t5_rdata", rd_cap[0], 32'hDEAD_BEEF);
    chk("t5_en_cnt", 32'(en_cnt), 32'h1);
    step();

    // Reset during the WAIT of a D read; request stays up.
    c0 = cyc;
    set_req(1, 32'h0000_0030, 32'h0, 4'h0);
    done[1] = 0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_no_ready", 32'(done[1]), 32'h0);
    run_until(1, 1, 20, "t6_timeout");
    chk("t6_ready_cyc", 32'(rdy_cyc[1]), 32'(c0 + 7));
    chk("t6_rdata", rd_cap[1], init_word(12));
    step();

    auto_on = 1'b1;
    repeat (400) step();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
